// File: rtl/match_scorekeeper.sv
// -----------------------------------------------------------------------------
// match_scorekeeper
//
// Best-of-N match sequencer placed after the Rock-Paper-Scissors game
// controller. On every round_done pulse it samples win_in/lose_in, classifies
// the round (win / lose / tie), updates the running scores, lights the
// matching round LED for HOLD_CYCLES cycles and declares the match result
// once either side reaches ROUNDS_TO_WIN points.
//
// Optional feature macro: MATCH_SCOREKEEPER_FORFEIT_EN
//   defined   : a round with win_in=0 and lose_in=0 is a forfeit, scored as a
//               computer point (round_lose_led) and able to end the match.
//   undefined : such a round is a tie (tie_count, round_tie_led).
//
// Parameters
//   ROUNDS_TO_WIN : points needed to win the match (1 .. 2^SCORE_W-1)
//   SCORE_W       : width of each score / tie counter
//   HOLD_CYCLES   : cycles the round LEDs stay lit (>= 1)
//
// Ports
//   clock           in   single clock, rising edge
//   reset_button    in   synchronous active-high reset, highest priority
//   round_done      in   one-cycle pulse: choices are locked
//   win_in          in   controller win output (sampled with round_done)
//   lose_in         in   controller lose output (sampled with round_done)
//   new_match       in   one-cycle pulse: clear scores, start new match
//   player_score    out  player points in the current match
//   computer_score  out  computer points in the current match
//   tie_count       out  ties in the current match, saturating
//   round_win_led   out  last round was a win (lit during HOLD)
//   round_lose_led  out  last round was a loss (lit during HOLD)
//   round_tie_led   out  last round was a tie (lit during HOLD)
//   match_win_led   out  match won by player (OVER only)
//   match_lose_led  out  match won by computer (OVER only)
//   busy            out  high while in HOLD
//   state_dbg       out  current FSM state (0=IDLE, 1=HOLD, 2=OVER)
//
// Handshake: round_done and new_match are single-cycle strobes with no
// back-pressure. round_done is consumed only in IDLE; pulses arriving in
// HOLD or OVER are dropped. new_match wins over round_done in the same cycle.
// All outputs are registered.
// -----------------------------------------------------------------------------
module match_scorekeeper #(
   parameter int ROUNDS_TO_WIN = 3,
   parameter int SCORE_W       = 4,
   parameter int HOLD_CYCLES   = 25_000_000
) (
   input  logic               clock,
   input  logic               reset_button,
   input  logic               round_done,
   input  logic               win_in,
   input  logic               lose_in,
   input  logic               new_match,
   output logic [SCORE_W-1:0] player_score,
   output logic [SCORE_W-1:0] computer_score,
   output logic [SCORE_W-1:0] tie_count,
   output logic               round_win_led,
   output logic               round_lose_led,
   output logic               round_tie_led,
   output logic               match_win_led,
   output logic               match_lose_led,
   output logic               busy,
   output logic [1:0]         state_dbg
);

   localparam int TW = $clog2(HOLD_CYCLES + 1);
   localparam logic [TW-1:0]      HOLD_LOAD = TW'(HOLD_CYCLES - 1);
   localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(ROUNDS_TO_WIN);
   localparam logic [SCORE_W-1:0] TIE_MAX   = '1;
   localparam logic [SCORE_W-1:0] ONE       = SCORE_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;

   assign state_dbg = state;

   always_ff @(posedge clock) begin
      if (reset_button || new_match) begin
         // Reset and new_match clear exactly the same set of registers.
         state          <= IDLE;
         timer          <= '0;
         player_score   <= '0;
         computer_score <= '0;
         tie_count      <= '0;
         round_win_led  <= 1'b0;
         round_lose_led <= 1'b0;
         round_tie_led  <= 1'b0;
         match_win_led  <= 1'b0;
         match_lose_led <= 1'b0;
         busy           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (round_done) begin
                  // win_in has priority over lose_in.
                  if (win_in) begin
                     player_score  <= player_score + ONE;
                     round_win_led <= 1'b1;
                  end else if (lose_in) begin
                     computer_score <= computer_score + ONE;
                     round_lose_led <= 1'b1;
                  end else begin
`ifdef MATCH_SCOREKEEPER_FORFEIT_EN
                     computer_score <= computer_score + ONE;
                     round_lose_led <= 1'b1;
`else
                     if (tie_count != TIE_MAX) begin
                        tie_count <= tie_count + ONE;
                     end
                     round_tie_led <= 1'b1;
`endif
                  end
                  timer <= HOLD_LOAD;
                  busy  <= 1'b1;
                  state <= HOLD;
               end
            end

            HOLD: begin
               if (timer == '0) begin
                  round_win_led  <= 1'b0;
                  round_lose_led <= 1'b0;
                  round_tie_led  <= 1'b0;
                  busy           <= 1'b0;
                  // Scores were updated on HOLD entry, so they are final here.
                  if (player_score == TARGET) begin
                     match_win_led <= 1'b1;
                     state         <= OVER;
                  end else if (computer_score == TARGET) begin
                     match_lose_led <= 1'b1;
                     state          <= OVER;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end

            OVER: begin
               // Terminal until new_match or reset.
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_match_scorekeeper.sv
// -----------------------------------------------------------------------------
// tb_match_scorekeeper
//
// Directed testbench for match_scorekeeper with ROUNDS_TO_WIN=3, SCORE_W=2,
// HOLD_CYCLES=4. Expected values come from hand-computed constants and a
// small score model kept in the bench. Works with or without
// MATCH_SCOREKEEPER_FORFEIT_EN defined.
// -----------------------------------------------------------------------------
module tb_match_scorekeeper;

   localparam int R  = 3;
   localparam int SW = 2;
   localparam int H  = 4;

   localparam int ST_IDLE = 0;
   localparam int ST_HOLD = 1;
   localparam int ST_OVER = 2;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset_button = 1'b1;
   logic          round_done   = 1'b0;
   logic          win_in       = 1'b0;
   logic          lose_in      = 1'b0;
   logic          new_match    = 1'b0;
   logic [SW-1:0] player_score;
   logic [SW-1:0] computer_score;
   logic [SW-1:0] tie_count;
   logic          round_win_led;
   logic          round_lose_led;
   logic          round_tie_led;
   logic          match_win_led;
   logic          match_lose_led;
   logic          busy;
   logic [1:0]    state_dbg;

   match_scorekeeper #(
      .ROUNDS_TO_WIN (R),
      .SCORE_W       (SW),
      .HOLD_CYCLES   (H)
   ) dut (
      .clock          (clock),
      .reset_button   (reset_button),
      .round_done     (round_done),
      .win_in         (win_in),
      .lose_in        (lose_in),
      .new_match      (new_match),
      .player_score   (player_score),
      .computer_score (computer_score),
      .tie_count      (tie_count),
      .round_win_led  (round_win_led),
      .round_lose_led (round_lose_led),
      .round_tie_led  (round_tie_led),
      .match_win_led  (match_win_led),
      .match_lose_led (match_lose_led),
      .busy           (busy),
      .state_dbg      (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   // expected model
   int exp_p, exp_c, exp_t;
   int exp_wl, exp_ll, exp_tl;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      round_done = 1'b0;
      win_in     = 1'b0;
      lose_in    = 1'b0;
      new_match  = 1'b0;
   endtask

   task automatic model_clear();
      exp_p = 0; exp_c = 0; exp_t = 0;
      exp_wl = 0; exp_ll = 0; exp_tl = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".player"},   int'(player_score),   0);
      check({tag, ".computer"}, int'(computer_score), 0);
      check({tag, ".ties"},     int'(tie_count),      0);
      check({tag, ".rwin"},     int'(round_win_led),  0);
      check({tag, ".rlose"},    int'(round_lose_led), 0);
      check({tag, ".rtie"},     int'(round_tie_led),  0);
      check({tag, ".mwin"},     int'(match_win_led),  0);
      check({tag, ".mlose"},    int'(match_lose_led), 0);
      check({tag, ".busy"},     int'(busy),           0);
      check({tag, ".state"},    int'(state_dbg),      ST_IDLE);
   endtask

   task automatic check_scores(input string tag);
      check({tag, ".player"},   int'(player_score),   exp_p);
      check({tag, ".computer"}, int'(computer_score), exp_c);
      check({tag, ".ties"},     int'(tie_count),      exp_t);
   endtask

   task automatic pulse_new_match();
      new_match = 1'b1;
      tick();
      clear_inputs();
      model_clear();
   endtask

   // Full round from IDLE: pulse, check LEDs/busy across HOLD, check exit.
   task automatic do_round(input string tag, input logic w, input logic l);
      int exp_state;
      round_done = 1'b1;
      win_in     = w;
      lose_in    = l;
      tick();
      clear_inputs();
      exp_wl = 0; exp_ll = 0; exp_tl = 0;
      if (w) begin
         exp_p++; exp_wl = 1;
      end else if (l) begin
         exp_c++; exp_ll = 1;
      end else begin
`ifdef MATCH_SCOREKEEPER_FORFEIT_EN
         exp_c++; exp_ll = 1;
`else
         if (exp_t < (1 << SW) - 1) exp_t++;
         exp_tl = 1;
`endif
      end
      // cycle N+1
      check_scores({tag, ".n1"});
      check({tag, ".n1.rwin"},  int'(round_win_led),  exp_wl);
      check({tag, ".n1.rlose"}, int'(round_lose_led), exp_ll);
      check({tag, ".n1.rtie"},  int'(round_tie_led),  exp_tl);
      check({tag, ".n1.busy"},  int'(busy),           1);
      // cycles N+2 .. N+H
      for (int k = 2; k <= H; k++) tick();
      check({tag, ".nH.busy"}, int'(busy), 1);
      // cycle N+H+1
      tick();
      exp_state = (exp_p == R || exp_c == R) ? ST_OVER : ST_IDLE;
      check({tag, ".exit.busy"},  int'(busy), 0);
      check({tag, ".exit.leds"},
            int'(round_win_led) + int'(round_lose_led) + int'(round_tie_led), 0);
      check({tag, ".exit.state"}, int'(state_dbg), exp_state);
      check({tag, ".exit.mwin"},  int'(match_win_led),  (exp_p == R) ? 1 : 0);
      check({tag, ".exit.mlose"}, int'(match_lose_led),
            (exp_p != R && exp_c == R) ? 1 : 0);
      check_scores({tag, ".exit"});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_clear();

      // Reset with random inputs for 2 cycles.
      reset_button = 1'b1;
      for (int i = 0; i < 2; i++) begin
         round_done = 1'($urandom_range(0, 1));
         win_in     = 1'($urandom_range(0, 1));
         lose_in    = 1'($urandom_range(0, 1));
         new_match  = 1'($urandom_range(0, 1));
         tick();
      end
      reset_button = 1'b0;
      clear_inputs();
      check_all_zero("reset");

      // Single win with an ignored lose pulse at N+2.
      round_done = 1'b1; win_in = 1'b1;
      tick();                                   // now N+1
      clear_inputs();
      check("win.n1.player", int'(player_score),  1);
      check("win.n1.rwin",   int'(round_win_led), 1);
      check("win.n1.busy",   int'(busy),          1);
      tick();                                   // now N+2
      check("win.n2.busy",   int'(busy),          1);
      round_done = 1'b1; lose_in = 1'b1;
      tick();                                   // now N+3
      clear_inputs();
      check("ign.n3.computer", int'(computer_score), 0);
      check("win.n3.rwin",     int'(round_win_led),  1);
      tick();                                   // now N+4
      check("win.n4.busy",     int'(busy),          1);
      check("win.n4.rwin",     int'(round_win_led), 1);
      tick();                                   // now N+5
      check("win.n5.busy",     int'(busy),          0);
      check("win.n5.rwin",     int'(round_win_led), 0);
      check("win.n5.state",    int'(state_dbg),     ST_IDLE);
      check("ign.n5.computer", int'(computer_score), 0);
      exp_p = 1;

      // No-choice round (tie or forfeit depending on build).
      do_round("nochoice", 1'b0, 1'b0);

      // Two more wins end the match.
      do_round("win2", 1'b1, 1'b0);
      do_round("win3", 1'b1, 1'b0);
      check("match.mwin", int'(match_win_led), 1);

      // Fourth round_done in OVER is ignored.
      round_done = 1'b1; win_in = 1'b1;
      tick();
      clear_inputs();
      tick();
      check("over.player", int'(player_score),  3);
      check("over.busy",   int'(busy),          0);
      check("over.rwin",   int'(round_win_led), 0);
      check("over.state",  int'(state_dbg),     ST_OVER);

      // new_match clears everything next cycle.
      pulse_new_match();
      check_all_zero("newmatch");

      // new_match and round_done together: round dropped.
      new_match = 1'b1; round_done = 1'b1; win_in = 1'b1;
      tick();
      clear_inputs();
      check_all_zero("collide.m1");
      tick();
      check("collide.m2.busy",   int'(busy),         0);
      check("collide.m2.player", int'(player_score), 0);

      // win_in has priority over lose_in; then a plain lose.
      do_round("both", 1'b1, 1'b1);
      do_round("lose", 1'b0, 1'b1);

      // Reset at N+2 of a HOLD.
      round_done = 1'b1; lose_in = 1'b1;
      tick();                                   // N+1
      clear_inputs();
      check("rsthold.n1.busy", int'(busy), 1);
      tick();                                   // N+2
      reset_button = 1'b1;
      tick();                                   // N+3
      reset_button = 1'b0;
      model_clear();
      check_all_zero("rsthold");

      // Saturation (ties) or forfeit match loss.
`ifdef MATCH_SCOREKEEPER_FORFEIT_EN
      for (int i = 0; i < R; i++) do_round("forfeit", 1'b0, 1'b0);
      check("forfeit.computer", int'(computer_score), 3);
      check("forfeit.mlose",    int'(match_lose_led), 1);
      check("forfeit.ties",     int'(tie_count),      0);
`else
      for (int i = 0; i < 5; i++) do_round("tie", 1'b0, 1'b0);
      check("tiesat.ties",  int'(tie_count),    3);
      check("tiesat.state", int'(state_dbg),    ST_IDLE);
      check("tiesat.mlose", int'(match_lose_led), 0);
`endif

      // ---------------- final report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/match_scorekeeper.md
# match_scorekeeper

Best-of-N match sequencer sitting directly downstream of the Rock-Paper-Scissors game controller. Each time the choices are locked, it samples the controller's win/lose outputs and classifies the round as a win, loss or tie. It keeps running scores, shows each round's result on LEDs for a fixed hold time, and declares the match winner when either side reaches the target score.

## Interface
- ROUNDS_TO_WIN, 3: points needed to win the match; legal range 1 to 2^SCORE_W-1.
- SCORE_W, 4: width of each score and tie counter.
- HOLD_CYCLES, 25_000_000: cycles the round-result LEDs stay lit; must be ≥1. The timer width is $clog2(HOLD_CYCLES+1).
- clock  in  1  single clock; all state changes on its rising edge.
- reset_button  in  1  synchronous, active-high reset; highest priority.
- round_done  in  1  one-cycle pulse marking that the player and computer choices are locked.
- win_in  in  1  controller win output; sampled only when round_done is high.
- lose_in  in  1  controller lose output; sampled only when round_done is high.
- new_match  in  1  one-cycle pulse that clears scores and starts a new match.
- player_score  out  SCORE_W  player points in the current match.
- computer_score  out  SCORE_W  computer points in the current match.
- tie_count  out  SCORE_W  ties in the current match; saturates at 2^SCORE_W-1.
- round_win_led, round_lose_led, round_tie_led  out  1  result of the last round, lit for the hold time; at most one is high.
- match_win_led, match_lose_led  out  1  match result; high only in OVER.
- busy  out  1  high while in HOLD.

## Operation
- FSM states: IDLE, HOLD, OVER. Reset enters IDLE and drives every output to 0.
- Round classification, made in the cycle round_done is high:
  - win_in=1: WIN. This takes priority if lose_in is also 1.
  - win_in=0 and lose_in=1: LOSE.
  - Both 0 (the player made no choice): TIE, unless the configuration macro changes it.
- IDLE, when round_done is high:
  - Increment the winning side's score, or tie_count.
  - Light the matching round LED.
  - Load the timer with HOLD_CYCLES-1.
  - Go to HOLD.
- HOLD:
  - round_done is ignored.
  - Each cycle: if the timer is 0, clear the round LEDs and leave HOLD; otherwise decrement the timer.
  - Exit to OVER if player_score or computer_score equals ROUNDS_TO_WIN; otherwise exit to IDLE.
- OVER:
  - match_win_led is high if player_score equals ROUNDS_TO_WIN; otherwise match_lose_led is high.
  - round_done is ignored.
- new_match, accepted in any state:
  - Clears the scores, tie_count, all LEDs and the timer.
  - Goes to IDLE. This aborts a HOLD in progress.
- Priority: reset_button first, then new_match, then round_done. If new_match and round_done are high in the same cycle, the round is dropped.
- Scores never exceed ROUNDS_TO_WIN, because the match ends at that value. Only tie_count needs saturation logic.

## Timing
- round_done high in cycle N while in IDLE:
  - The updated score and round LED are visible at N+1.
  - busy is high for cycles N+1 through N+HOLD_CYCLES.
  - At N+HOLD_CYCLES+1 the round LEDs and busy are 0, and the state is IDLE or OVER. In OVER, the match LED is high in that same cycle.
- new_match or reset_button in cycle M: all cleared outputs read 0 at M+1.
- All outputs are registered; there is no combinational path from any input to any output.
- A following round_done is accepted no earlier than N+HOLD_CYCLES+1.

## Configuration
- MATCH_SCOREKEEPER_FORFEIT_EN:
  - Defined: a round with win_in=0 and lose_in=0 counts as a forfeit. It increments computer_score and lights round_lose_led, and it can end the match.
  - Undefined: such a round is a TIE. It increments tie_count, lights round_tie_led, and never ends the match.

## Test plan
- Reset: assert reset_button for 2 cycles with random inputs -> all outputs 0 and the state is IDLE on the cycle after release.
- Single win (HOLD_CYCLES=4): round_done with win_in=1 at cycle N -> player_score=1, round_win_led=1 and busy=1 at N+1 through N+4; both LED and busy are 0 at N+5.
- Ignored pulses: round_done with lose_in=1 at N+2 during HOLD -> computer_score stays 0.
- Match end (ROUNDS_TO_WIN=3): three separated win rounds -> match_win_led=1 at HOLD_CYCLES+1 cycles after the third round_done. A fourth round_done leaves player_score=3. new_match then gives all scores and LEDs 0 one cycle later.
- No-choice round:
  - Macro undefined: tie_count=1 and round_tie_led=1.
  - Macro defined: computer_score=1 and round_lose_led=1.
  - Tie saturation (SCORE_W=2, macro undefined): five ties -> tie_count=3.
- Collisions: reset_button at N+2 of a HOLD -> all 0 at N+3. new_match and round_done high in the same IDLE cycle -> scores remain 0 and busy stays 0.
